// File: rtl/sram_1rw1r_wmask_init.sv
// One read/write plus one read-only port SRAM with per-lane write mask and a
// self-clearing controller that fills the array with INIT_VALUE after reset or on request.
module sram_1rw1r_wmask_init #(
    parameter int unsigned DATA_WIDTH  = 2,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned WMASK_WIDTH = 1,
    parameter int unsigned WRITE_FIRST = 1,
    parameter int unsigned OUT_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   init,
    output logic                   busy,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dout0_vld,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_vld
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LANE_W    = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic                    busy_nxt;
    logic                    clr_we;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    wr0, rd0, rd1;
    logic [DATA_WIDTH-1:0]   bit_mask;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [DATA_WIDTH-1:0]   rd0_word, rd1_word;

    // Controller state register; busy is tracked alongside the state.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
        end
    end

    // Clear sequencing: one address per cycle, init requests only honoured in READY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        clr_we    = 1'b0;
        case (state)
            ST_INIT: begin
                clr_we = 1'b1;
                if (cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                if (init) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
                busy_nxt  = 1'b1;
            end
        endcase
    end

    assign wr0 = !busy && !csb0 && !web0;
    assign rd0 = !busy && !csb0 &&  web0;
    assign rd1 = !busy && !csb1;

    // Expand lane enables into a per-bit mask.
    always_comb begin
        bit_mask = '0;
        for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
            bit_mask[i*LANE_W +: LANE_W] = {LANE_W{wmask0[i]}};
        end
    end

    assign wr_word  = (mem[addr0] & ~bit_mask) | (din0 & bit_mask);
    assign rd0_word = mem[addr0];
    // Same-edge collision on port 1 optionally forwards the merged write word.
    assign rd1_word = ((WRITE_FIRST != 0) && wr0 && (addr0 == addr1)) ? wr_word : mem[addr1];

    // Array storage; the clear sequence has priority over port-0 writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= INIT_VALUE;
        end else if (wr0) begin
            mem[addr0] <= wr_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] p0_data, p1_data;
        logic                  p0_vld, p1_vld;

        // Read capture stage followed by the output stage; data holds when not valid.
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                p0_data   <= '0;
                p1_data   <= '0;
                p0_vld    <= 1'b0;
                p1_vld    <= 1'b0;
                dout0     <= '0;
                dout1     <= '0;
                dout0_vld <= 1'b0;
                dout1_vld <= 1'b0;
            end else begin
                p0_vld    <= rd0;
                p1_vld    <= rd1;
                dout0_vld <= p0_vld;
                dout1_vld <= p1_vld;
                if (rd0)    p0_data <= rd0_word;
                if (rd1)    p1_data <= rd1_word;
                if (p0_vld) dout0   <= p0_data;
                if (p1_vld) dout1   <= p1_data;
            end
        end
    end else begin : g_out_direct
        // Single read stage; data holds when not valid.
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                dout0     <= '0;
                dout1     <= '0;
                dout0_vld <= 1'b0;
                dout1_vld <= 1'b0;
            end else begin
                dout0_vld <= rd0;
                dout1_vld <= rd1;
                if (rd0) dout0 <= rd0_word;
                if (rd1) dout1 <= rd1_word;
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw1r_wmask_init.sv
// Directed bench: a default-parameter instance and a 16-bit, two-lane,
// read-first, output-registered instance cleared to 16'hAAAA.
module tb_sram_1rw1r_wmask_init;

    logic clk;
    logic rstb;

    logic        a_init, a_busy, a_csb0, a_web0, a_csb1;
    logic [0:0]  a_wmask0;
    logic [3:0]  a_addr0, a_addr1;
    logic [1:0]  a_din0, a_dout0, a_dout1;
    logic        a_dout0_vld, a_dout1_vld;

    logic        b_init, b_busy, b_csb0, b_web0, b_csb1;
    logic [1:0]  b_wmask0;
    logic [3:0]  b_addr0, b_addr1;
    logic [15:0] b_din0, b_dout0, b_dout1;
    logic        b_dout0_vld, b_dout1_vld;

    int checks;
    int failures;

    sram_1rw1r_wmask_init u_a (
        .clk(clk), .rstb(rstb), .init(a_init), .busy(a_busy),
        .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0), .addr0(a_addr0),
        .din0(a_din0), .dout0(a_dout0), .dout0_vld(a_dout0_vld),
        .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1), .dout1_vld(a_dout1_vld)
    );

    sram_1rw1r_wmask_init #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .WMASK_WIDTH(2),
        .WRITE_FIRST(0), .OUT_REG(1), .INIT_VALUE(16'hAAAA)
    ) u_b (
        .clk(clk), .rstb(rstb), .init(b_init), .busy(b_busy),
        .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0), .addr0(b_addr0),
        .din0(b_din0), .dout0(b_dout0), .dout0_vld(b_dout0_vld),
        .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1), .dout1_vld(b_dout1_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_csb0 = 1'b1; a_web0 = 1'b1; a_csb1 = 1'b1; a_init = 1'b0;
    endtask

    task automatic b_idle();
        b_csb0 = 1'b1; b_web0 = 1'b1; b_csb1 = 1'b1; b_init = 1'b0;
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [1:0] data, input logic [0:0] mask);
        a_csb0 = 1'b0; a_web0 = 1'b0; a_addr0 = addr; a_din0 = data; a_wmask0 = mask;
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] mask);
        b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = addr; b_din0 = data; b_wmask0 = mask;
    endtask

    // Read every address on both ports of u_a, expecting the given word.
    task automatic a_read_all(input logic [1:0] exp);
        for (int a = 0; a < 16; a++) begin
            a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 4'(a);
            a_csb1 = 1'b0; a_addr1 = 4'(15 - a);
            tick();
            chk("readall_d0", 32'(a_dout0), 32'(exp));
            chk("readall_v0", 32'(a_dout0_vld), 32'd1);
            chk("readall_d1", 32'(a_dout1), 32'(exp));
            chk("readall_v1", 32'(a_dout1_vld), 32'd1);
        end
        a_idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rstb = 1'b0;
        a_idle(); b_idle();
        a_wmask0 = '0; a_addr0 = '0; a_addr1 = '0; a_din0 = '0;
        b_wmask0 = '0; b_addr0 = '0; b_addr1 = '0; b_din0 = '0;

        // Reset state
        tick(); tick();
        chk("rst_busy_a", 32'(a_busy), 32'd1);
        chk("rst_dout0_a", 32'(a_dout0), 32'd0);
        chk("rst_vld1_a", 32'(a_dout1_vld), 32'd0);
        chk("rst_busy_b", 32'(b_busy), 32'd1);
        chk("rst_dout1_b", 32'(b_dout1), 32'd0);

        // Release reset with reads requested throughout the clear
        rstb = 1'b1;
        a_csb0 = 1'b0; a_web0 = 1'b1; a_csb1 = 1'b0; a_addr0 = 4'd1; a_addr1 = 4'd2;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("boot_busy", 32'(a_busy), (k < 16) ? 32'd1 : 32'd0);
            chk("boot_vld0", 32'(a_dout0_vld), 32'd0);
            chk("boot_vld1", 32'(a_dout1_vld), 32'd0);
        end
        chk("boot_busy_b", 32'(b_busy), 32'd0);
        a_idle();
        a_read_all(2'b00);

        // Write then read on port 1
        a_write(4'd5, 2'b10, 1'b1);
        tick();
        chk("wr_no_vld0", 32'(a_dout0_vld), 32'd0);
        chk("wr_hold_d0", 32'(a_dout0), 32'd0);
        a_idle(); a_csb1 = 1'b0; a_addr1 = 4'd5;
        tick();
        chk("rd5_d1", 32'(a_dout1), 32'h2);
        chk("rd5_v1", 32'(a_dout1_vld), 32'd1);
        a_idle();
        tick();
        chk("idle_v1", 32'(a_dout1_vld), 32'd0);
        chk("idle_hold_d1", 32'(a_dout1), 32'h2);

        // Masked-off write leaves the word alone
        a_write(4'd5, 2'b01, 1'b0);
        tick();
        a_idle(); a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 4'd5;
        tick();
        chk("mask0_d0", 32'(a_dout0), 32'h2);
        chk("mask0_v0", 32'(a_dout0_vld), 32'd1);

        // Write-first collision
        a_write(4'd3, 2'b01, 1'b1); a_csb1 = 1'b1;
        tick();
        a_write(4'd3, 2'b11, 1'b1); a_csb1 = 1'b0; a_addr1 = 4'd3;
        tick();
        chk("coll_wf_d1", 32'(a_dout1), 32'h3);
        chk("coll_wf_v1", 32'(a_dout1_vld), 32'd1);
        a_idle(); a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 4'd3;
        tick();
        chk("coll_after_d0", 32'(a_dout0), 32'h3);
        a_idle();
        tick();
        chk("hold_v0", 32'(a_dout0_vld), 32'd0);
        chk("hold_d0", 32'(a_dout0), 32'h3);

        // Wide instance: registered output latency and lane masking
        b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = 4'd2;
        tick();
        chk("b_lat_v0", 32'(b_dout0_vld), 32'd0);
        b_idle();
        tick();
        chk("b_init_d0", 32'(b_dout0), 32'hAAAA);
        chk("b_init_v0", 32'(b_dout0_vld), 32'd1);
        b_write(4'd2, 16'h1234, 2'b01);
        tick();
        b_idle(); b_csb0 = 1'b0; b_addr0 = 4'd2;
        tick();
        b_idle();
        tick();
        chk("b_lane0_d0", 32'(b_dout0), 32'hAA34);
        b_write(4'd2, 16'h5600, 2'b10);
        tick();
        b_idle(); b_csb0 = 1'b0; b_addr0 = 4'd2;
        tick();
        b_idle();
        tick();
        chk("b_lane1_d0", 32'(b_dout0), 32'h5634);

        // Read-first collision
        b_write(4'd3, 16'h0001, 2'b11);
        tick();
        b_write(4'd3, 16'h0003, 2'b11); b_csb1 = 1'b0; b_addr1 = 4'd3;
        tick();
        chk("b_coll_lat", 32'(b_dout1_vld), 32'd0);
        b_idle();
        tick();
        chk("b_coll_rf_d1", 32'(b_dout1), 32'h0001);
        chk("b_coll_rf_v1", 32'(b_dout1_vld), 32'd1);
        b_csb1 = 1'b0; b_addr1 = 4'd3;
        tick();
        b_idle();
        tick();
        chk("b_after_d1", 32'(b_dout1), 32'h0003);

        // Re-clear via init, with reads and a stray init pulse during busy
        a_init = 1'b1;
        tick();
        chk("reinit_busy", 32'(a_busy), 32'd1);
        a_init = 1'b0;
        a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 4'd5; a_csb1 = 1'b0; a_addr1 = 4'd3;
        for (int k = 1; k <= 16; k++) begin
            a_init = (k == 6);
            tick();
            chk("reinit_busy_k", 32'(a_busy), (k < 16) ? 32'd1 : 32'd0);
            chk("reinit_vld0", 32'(a_dout0_vld), 32'd0);
            chk("reinit_vld1", 32'(a_dout1_vld), 32'd0);
            chk("reinit_hold0", 32'(a_dout0), 32'h3);
            chk("reinit_hold1", 32'(a_dout1), 32'h3);
        end
        a_init = 1'b0;
        tick();
        chk("reinit_d0", 32'(a_dout0), 32'd0);
        chk("reinit_v0", 32'(a_dout0_vld), 32'd1);
        chk("reinit_d1", 32'(a_dout1), 32'd0);
        a_idle();
        a_read_all(2'b00);

        // Reset in the middle of a clear
        a_write(4'd10, 2'b11, 1'b1);
        tick();
        a_idle(); a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 4'd10; a_csb1 = 1'b0; a_addr1 = 4'd10;
        tick();
        chk("pre_rst_d0", 32'(a_dout0), 32'h3);
        chk("pre_rst_d1", 32'(a_dout1), 32'h3);
        a_idle();
        a_init = 1'b1;
        tick();
        a_init = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        #2 rstb = 1'b0;
        #1;
        chk("midrst_busy", 32'(a_busy), 32'd1);
        chk("midrst_d0", 32'(a_dout0), 32'd0);
        chk("midrst_d1", 32'(a_dout1), 32'd0);
        chk("midrst_b_d0", 32'(b_dout0), 32'd0);
        tick();
        rstb = 1'b1;
        a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 4'd10; a_csb1 = 1'b0; a_addr1 = 4'd10;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("rerst_busy", 32'(a_busy), (k < 16) ? 32'd1 : 32'd0);
            chk("rerst_d0", 32'(a_dout0), 32'd0);
            chk("rerst_d1", 32'(a_dout1), 32'd0);
            chk("rerst_v0", 32'(a_dout0_vld), 32'd0);
        end
        tick();
        chk("rerst_a10_d0", 32'(a_dout0), 32'd0);
        chk("rerst_a10_v0", 32'(a_dout0_vld), 32'd1);
        chk("rerst_a10_d1", 32'(a_dout1), 32'd0);
        a_idle();
        b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = 4'd2;
        tick();
        b_idle();
        tick();
        chk("rerst_b_d0", 32'(b_dout0), 32'hAAAA);
        chk("rerst_b_v0", 32'(b_dout0_vld), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
